serial_subtractor_8bit: RTL
===========================

Name: serial_subtractor_8bit

Overview:
- Bit-serial, multi-cycle subtractor. Computes diff = a - b - bin, LSB first, one bit per clock.
- Provides borrow out (bout).
- Companion to the parallel carry look-ahead adder. Used where area matters more than latency, and as a reference model for cross-checking adder results (a + b = s implies s - b = a).
- Start/done handshake toward the requesting controller.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled at rising clk edge.
- a  input  WIDTH  minuend; sampled only when start is accepted.
- b  input  WIDTH  subtrahend; sampled only when start is accepted.
- bin  input  1  borrow in; sampled only when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; diff and bout are valid from this cycle on.
- diff  output  WIDTH  difference, registered.
- bout  output  1  final borrow out, registered.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, diff=0, bout=0. Internal shift registers, bit counter and borrow flop are cleared. Applies immediately, including mid-operation. The aborted operation produces no done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load a, b and the borrow flop (<=bin) into internal registers; counter=0; go to RUN; busy=1 from the next cycle.
  - start=0: stay in IDLE.
- RUN, at each edge:
  - d = a_sh[0] ^ b_sh[0] ^ brw.
  - brw <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
  - Shift d into result register from the MSB side; shift a_sh and b_sh right by one.
  - counter += 1.
  - At the edge where counter == WIDTH-1: diff <= full result including that bit; bout <= new borrow; done <= 1; busy <= 0; go to DONE.
- DONE: lasts exactly one cycle with done=1.
  - start=1: accept as in IDLE (back-to-back) and go to RUN.
  - Otherwise go to IDLE.
  - done deasserts on the following edge in either case.
- Latency: start accepted at edge k -> done=1 in the cycle following edge k+WIDTH (8 cycles for WIDTH=8). Throughput is one result per WIDTH+1 cycles when start is held high.
- start while busy=1 (RUN) is ignored; the operands on a/b/bin at that time are discarded.
- diff and bout hold their values until the next completion or reset. They do not change during RUN.
- Arithmetic is modulo 2^WIDTH. bout=1 iff a < b + bin (unsigned).
- Counter width is clog2(WIDTH). Counter wrap never occurs because the FSM exits at WIDTH-1.

Optional Feature:
- Macro SUB_OVERFLOW_FLAG_EN.
- Defined:
  - Extra output port ovf (1 bit), registered.
  - Updated with diff at done.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), i.e. two's-complement signed overflow of a - b - bin, using the original MSBs captured at start.
  - Reset value 0.
- Undefined: ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- rst=1 asserted mid-RUN (after 3 bits of a=83, b=7) -> busy, done, diff, bout all 0 immediately. No done pulse follows. A fresh start with a=83, b=7, bin=0 then yields diff=76, bout=0.
- a=14, b=1, bin=1, start pulse -> done exactly 8 cycles later; diff=12, bout=0. busy high for those 8 cycles.
- a=5, b=9, bin=0 -> diff=252, bout=1. a=0, b=0, bin=1 -> diff=255, bout=1.
- start held high with a=223, b=54, bin=1 -> diff=168, bout=0. Second result follows with done pulses 9 cycles apart. A start pulse issued during RUN with a=1, b=1 is ignored; diff stays 168.
- SUB_OVERFLOW_FLAG_EN defined:
  - a=127, b=255, bin=0 -> diff=128, bout=1, ovf=1.
  - a=79, b=135, bin=1 -> diff=199, bout=1, ovf=1.
  - a=67, b=59, bin=1 -> diff=7, ovf=0.

Source files
------------

// File: rtl/serial_subtractor_8bit_if.sv
// Start/done request bus between a controller (master) and the serial subtractor (slave).
// SUB_OVERFLOW_FLAG_EN adds the signed-overflow flag ovf to the bus.
interface serial_subtractor_8bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock, start/done handshake.
// Optional macro SUB_OVERFLOW_FLAG_EN adds a registered two's-complement overflow flag (bus.ovf).
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_subtractor_8bit_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;
  logic             load;
  logic             finish;
  logic             diff_bit;

  // A new request is only accepted when no operation is in flight.
  assign load     = bus.start && (state_q == IDLE || state_q == DONE);
  assign finish   = (state_q == RUN) && (cnt_q == LAST);
  assign diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
    case (state_q)
      IDLE, DONE: begin
        if (load) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        brw_d  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
        res_d  = {diff_bit, res_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // Publish on the last bit so diff/bout never show partial results.
        if (finish) begin
          diff_d  = res_d;
          bout_d  = brw_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

`ifdef SUB_OVERFLOW_FLAG_EN
  // Operand MSBs are consumed by the shifters, so keep the originals for the overflow test.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (load) begin
      a_msb_d = bus.a[WIDTH-1];
      b_msb_d = bus.b[WIDTH-1];
    end
    if (finish)
      ovf_d = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule
